// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS load/store unit: opcodes, FSM states, lane helper types.
package mips_mem_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SWL = 6'h2A;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SWR = 6'h2E;

  typedef enum logic [2:0] {
    IDLE,
    RD_CMD,
    RD_WAIT,
    WR_CMD,
    RESP
  } lsu_state_e;

  // Byte offset within the 32-bit word, and the matching per-lane enable mask.
  typedef logic [1:0] lane_t;
  typedef logic [3:0] byte_en_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables, store data, load extract/merge, misalign flag.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [5:0]  op,
  input  lane_t       lane,
  input  logic [31:0] rt_data,
  input  logic [31:0] rdata,
  output byte_en_t    byteenable,
  output logic [31:0] writedata,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        is_load,
  output logic        is_store
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [4:0]  sh_lo;  // 8*a
  logic [4:0]  sh_hi;  // 8*(3-a); 3-a equals ~a for a 2-bit lane

  assign sh_lo = {lane, 3'b000};
  assign sh_hi = {~lane, 3'b000};
  assign rhalf = lane[1] ? rdata[31:16] : rdata[15:0];

  // Select the addressed byte of the returned word.
  always_comb begin
    case (lane)
      2'd0:    rbyte = rdata[7:0];
      2'd1:    rbyte = rdata[15:8];
      2'd2:    rbyte = rdata[23:16];
      default: rbyte = rdata[31:24];
    endcase
  end

  // Decode the opcode into lane enables, store data and load result.
  always_comb begin
    byteenable = '0;
    writedata  = '0;
    load_data  = '0;
    misaligned = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    case (op)
      OP_LB: begin
        is_load    = 1'b1;
        byteenable = 4'b0001 << lane;
        load_data  = {{24{rbyte[7]}}, rbyte};
      end
      OP_LBU: begin
        is_load    = 1'b1;
        byteenable = 4'b0001 << lane;
        load_data  = {24'h0, rbyte};
      end
      OP_LH: begin
        is_load    = 1'b1;
        misaligned = lane[0];
        byteenable = lane[1] ? 4'b1100 : 4'b0011;
        load_data  = {{16{rhalf[15]}}, rhalf};
      end
      OP_LHU: begin
        is_load    = 1'b1;
        misaligned = lane[0];
        byteenable = lane[1] ? 4'b1100 : 4'b0011;
        load_data  = {16'h0, rhalf};
      end
      OP_LW: begin
        is_load    = 1'b1;
        misaligned = (lane != 2'b00);
        byteenable = 4'b1111;
        load_data  = rdata;
      end
      OP_LWL: begin
        // Memory bytes a..0 land in the top of rt; the low 3-a bytes of rt survive.
        is_load    = 1'b1;
        byteenable = 4'b1111 >> (~lane);
        load_data  = (rdata << sh_hi) | (rt_data & (32'h00FF_FFFF >> sh_lo));
      end
      OP_LWR: begin
        // Memory bytes 3..a land in the bottom of rt; the high a bytes of rt survive.
        is_load    = 1'b1;
        byteenable = 4'b1111 << lane;
        load_data  = (rdata >> sh_lo) | (rt_data & ~(32'hFFFF_FFFF >> sh_lo));
      end
      OP_SB: begin
        is_store   = 1'b1;
        byteenable = 4'b0001 << lane;
        writedata  = {4{rt_data[7:0]}};
      end
      OP_SH: begin
        is_store   = 1'b1;
        misaligned = lane[0];
        byteenable = lane[1] ? 4'b1100 : 4'b0011;
        writedata  = {2{rt_data[15:0]}};
      end
      OP_SW: begin
        is_store   = 1'b1;
        misaligned = (lane != 2'b00);
        byteenable = 4'b1111;
        writedata  = rt_data;
      end
      OP_SWL: begin
        is_store   = 1'b1;
        byteenable = 4'b1111 >> (~lane);
        writedata  = rt_data >> sh_hi;
      end
      OP_SWR: begin
        is_store   = 1'b1;
        byteenable = 4'b1111 << lane;
        writedata  = rt_data << sh_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MIPS load/store unit: one access at a time onto a pipelined, waitrequest-style memory bus.
module load_store_unit
  import mips_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] rt_data,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_writedata,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  input  logic        mem_readdatavalid
);

  lsu_state_e  state_q, state_d;
  logic [5:0]  op_q;
  lane_t       lane_q;
  logic [31:0] rt_q;
  logic [31:0] addr_q;
  byte_en_t    be_q;
  logic [31:0] wdata_q;
  logic [31:0] wait_cnt_q;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_error_q, resp_error_d;

  logic        in_idle, accept, timeout_hit;
  logic [5:0]  al_op;
  lane_t       al_lane;
  logic [31:0] al_rt;
  byte_en_t    al_be;
  logic [31:0] al_wdata, al_load;
  logic        al_misaligned, al_is_load, al_is_store;

  assign in_idle = (state_q == IDLE);
  assign accept  = req_valid && req_ready;

  // The aligner sees live inputs while idle (to decode the new request) and the captured
  // request afterwards, so one instance serves both accept and load-data merge.
  assign al_op   = in_idle ? op : op_q;
  assign al_lane = in_idle ? addr[1:0] : lane_q;
  assign al_rt   = in_idle ? rt_data : rt_q;

  mem_lane_align u_align (
    .op         (al_op),
    .lane       (al_lane),
    .rt_data    (al_rt),
    .rdata      (mem_readdata),
    .byteenable (al_be),
    .writedata  (al_wdata),
    .load_data  (al_load),
    .misaligned (al_misaligned),
    .is_load    (al_is_load),
    .is_store   (al_is_store)
  );

  // Fires on the TIMEOUT_CYCLES-th bus cycle of an access; completion in that cycle still wins.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt_q >= TIMEOUT_CYCLES - 1);

  // Next-state and response data selection.
  always_comb begin
    state_d      = state_q;
    resp_data_d  = resp_data_q;
    resp_error_d = resp_error_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if ((!al_is_load && !al_is_store) || al_misaligned) begin
            state_d      = RESP;
            resp_data_d  = '0;
            resp_error_d = 1'b1;
          end else if (al_is_load) begin
            state_d = RD_CMD;
          end else begin
            state_d = WR_CMD;
          end
        end
      end
      RD_CMD: begin
        if (!mem_waitrequest) begin
          state_d = RD_WAIT;
        end else if (timeout_hit) begin
          state_d      = RESP;
          resp_data_d  = '0;
          resp_error_d = 1'b1;
        end
      end
      RD_WAIT: begin
        if (mem_readdatavalid) begin
          state_d      = RESP;
          resp_data_d  = al_load;
          resp_error_d = 1'b0;
        end else if (timeout_hit) begin
          state_d      = RESP;
          resp_data_d  = '0;
          resp_error_d = 1'b1;
        end
      end
      WR_CMD: begin
        if (!mem_waitrequest) begin
          state_d      = RESP;
          resp_data_d  = '0;
          resp_error_d = 1'b0;
        end else if (timeout_hit) begin
          state_d      = RESP;
          resp_data_d  = '0;
          resp_error_d = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      resp_data_q  <= '0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
    end
  end

  // Request capture at accept, plus the per-access bus wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= '0;
      lane_q     <= '0;
      rt_q       <= '0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      wait_cnt_q <= '0;
    end else if (accept) begin
      op_q       <= op;
      lane_q     <= addr[1:0];
      rt_q       <= rt_data;
      addr_q     <= {addr[31:2], 2'b00};
      be_q       <= al_be;
      wdata_q    <= al_wdata;
      wait_cnt_q <= '0;
    end else if (state_q inside {RD_CMD, RD_WAIT, WR_CMD}) begin
      if (wait_cnt_q != '1) wait_cnt_q <= wait_cnt_q + 32'd1;
    end
  end

  assign req_ready      = in_idle && !reset;
  assign resp_valid     = (state_q == RESP);
  assign resp_data      = resp_data_q;
  assign resp_error     = resp_error_q;
  assign mem_read       = (state_q == RD_CMD);
  assign mem_write      = (state_q == WR_CMD);
  assign mem_address    = addr_q;
  assign mem_byteenable = be_q;
  assign mem_writedata  = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised and directed bench for load_store_unit against a byte-level reference model.
module tb_load_store_unit;

  localparam int TMO = 8;
  localparam logic [5:0] LB  = 6'h20, LH  = 6'h21, LWL = 6'h22, LW  = 6'h23;
  localparam logic [5:0] LBU = 6'h24, LHU = 6'h25, LWR = 6'h26, SB  = 6'h28;
  localparam logic [5:0] SH  = 6'h29, SWL = 6'h2A, SW  = 6'h2B, SWR = 6'h2E;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready;
  logic [5:0]  op;
  logic [31:0] addr, rt_data;
  logic        resp_valid, resp_error;
  logic [31:0] resp_data;
  logic [31:0] mem_address, mem_writedata, mem_readdata;
  logic        mem_read, mem_write, mem_waitrequest, mem_readdatavalid;
  logic [3:0]  mem_byteenable;

  int checks = 0;
  int errors = 0;

  logic [5:0] ops [12] = '{LB, LH, LWL, LW, LBU, LHU, LWR, SB, SH, SWL, SW, SWR};

  typedef struct {
    int          lat;
    logic [31:0] data;
    logic        err;
    logic        rd_seen;
    logic        wr_seen;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        stable;
    logic        one_shot;
    logic        strobe_at_resp;
    logic        ready;
    int          cmd_cycles;
  } obs_t;

  typedef struct {
    logic        ld;
    logic        st;
    logic        bad;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] res;
    int          lat;
    logic        err;
  } exp_t;

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .op                (op),
    .addr              (addr),
    .rt_data           (rt_data),
    .resp_valid        (resp_valid),
    .resp_data         (resp_data),
    .resp_error        (resp_error),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_byteenable    (mem_byteenable),
    .mem_writedata     (mem_writedata),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdata      (mem_readdata),
    .mem_readdatavalid (mem_readdatavalid)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model built from byte lanes; wr = waitrequest cycles, rd = readdata delay (<0 never).
  function automatic exp_t model(input logic [5:0] o, input logic [31:0] ad, input logic [31:0] rt,
                                 input logic [31:0] mw, input int wr, input int rd);
    exp_t e;
    int a, first, done;
    logic [7:0] m [4];
    logic [7:0] r [4];
    logic [7:0] q [4];
    a = int'(ad[1:0]);
    for (int i = 0; i < 4; i++) begin
      m[i] = mw[8*i +: 8];
      r[i] = rt[8*i +: 8];
      q[i] = 8'h00;
    end
    e.ld = 0; e.st = 0; e.bad = 0; e.be = 0; e.wd = 0; e.res = 0;
    case (o)
      LB, LBU: begin
        e.ld = 1; e.be[a] = 1'b1;
        e.res = (o == LB) ? {{24{m[a][7]}}, m[a]} : {24'h0, m[a]};
      end
      LH, LHU: begin
        e.ld = 1; e.bad = (a % 2) != 0;
        if (!e.bad) begin
          e.be[a] = 1'b1; e.be[a+1] = 1'b1;
          e.res = (o == LH) ? {{16{m[a+1][7]}}, m[a+1], m[a]} : {16'h0, m[a+1], m[a]};
        end
      end
      LW: begin e.ld = 1; e.bad = (a != 0); e.be = 4'hF; e.res = mw; end
      LWL: begin
        e.ld = 1;
        for (int i = 0; i <= a; i++) e.be[i] = 1'b1;
        for (int k = 0; k < 4; k++) begin
          if (k >= 3 - a) q[k] = m[k - (3 - a)];
          else q[k] = r[k];
        end
        e.res = {q[3], q[2], q[1], q[0]};
      end
      LWR: begin
        e.ld = 1;
        for (int i = a; i < 4; i++) e.be[i] = 1'b1;
        for (int k = 0; k < 4; k++) begin
          if (k <= 3 - a) q[k] = m[k + a];
          else q[k] = r[k];
        end
        e.res = {q[3], q[2], q[1], q[0]};
      end
      SB: begin e.st = 1; e.be[a] = 1'b1; e.wd = {r[0], r[0], r[0], r[0]}; end
      SH: begin
        e.st = 1; e.bad = (a % 2) != 0;
        if (!e.bad) begin e.be[a] = 1'b1; e.be[a+1] = 1'b1; end
        e.wd = {r[1], r[0], r[1], r[0]};
      end
      SW: begin e.st = 1; e.bad = (a != 0); e.be = 4'hF; e.wd = rt; end
      SWL: begin
        e.st = 1;
        for (int i = 0; i <= a; i++) e.be[i] = 1'b1;
        for (int k = 0; k <= a; k++) q[k] = r[k + 3 - a];
        e.wd = {q[3], q[2], q[1], q[0]};
      end
      SWR: begin
        e.st = 1;
        for (int i = a; i < 4; i++) e.be[i] = 1'b1;
        for (int k = a; k < 4; k++) q[k] = r[k - a];
        e.wd = {q[3], q[2], q[1], q[0]};
      end
      default: e.bad = 1;
    endcase
    if (e.bad) begin
      e.lat = 1; e.err = 1; e.res = 0;
    end else begin
      first = 1 + wr;
      if (e.st) done = first;
      else done = (rd < 0) ? 1000 : first + 1 + rd;
      if (done > TMO) begin e.err = 1; e.lat = TMO + 1; e.res = 0; end
      else begin e.err = 0; e.lat = done + 1; end
      if (e.st) e.res = 0;
    end
    return e;
  endfunction

  // Issue one request and play the memory side; cycle 1 is the first cycle after accept.
  task automatic do_access(input logic [5:0] o, input logic [31:0] ad, input logic [31:0] rt,
                           input logic [31:0] mw, input int wr, input int rd, output obs_t ob);
    int valid_at;
    logic [70:0] snap;
    ob.lat = -1; ob.data = 0; ob.err = 0; ob.rd_seen = 0; ob.wr_seen = 0;
    ob.addr = 0; ob.be = 0; ob.wd = 0; ob.stable = 1; ob.one_shot = 0;
    ob.strobe_at_resp = 0; ob.cmd_cycles = 0;
    snap = '0;
    valid_at = -1;
    @(negedge clk);
    ob.ready = req_ready;
    req_valid = 1; op = o; addr = ad; rt_data = rt;
    mem_waitrequest = 0; mem_readdatavalid = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        req_valid = 0; op = 6'($urandom); addr = $urandom; rt_data = $urandom;
      end
      mem_readdatavalid = 0;
      mem_readdata = $urandom;
      if (resp_valid) begin
        ob.lat = cyc; ob.data = resp_data; ob.err = resp_error;
        ob.strobe_at_resp = mem_read | mem_write;
        @(negedge clk);
        ob.one_shot = !resp_valid && req_ready;
        break;
      end
      if (mem_read || mem_write) begin
        ob.cmd_cycles++;
        if (ob.cmd_cycles == 1) begin
          snap = {mem_read, mem_write, mem_address, mem_byteenable, mem_writedata};
          ob.addr = mem_address; ob.be = mem_byteenable; ob.wd = mem_writedata;
        end else if ({mem_read, mem_write, mem_address, mem_byteenable, mem_writedata} !== snap) begin
          ob.stable = 0;
        end
        ob.rd_seen |= mem_read;
        ob.wr_seen |= mem_write;
        mem_waitrequest = (ob.cmd_cycles <= wr);
        if (mem_read && !mem_waitrequest) valid_at = (rd < 0) ? -1 : cyc + 1 + rd;
      end else begin
        mem_waitrequest = 1'($urandom_range(0, 1));
      end
      if (cyc == valid_at) begin
        mem_readdatavalid = 1; mem_readdata = mw;
      end
    end
    mem_waitrequest = 0; mem_readdatavalid = 0;
  endtask

  task automatic test_reset();
    reset = 1; req_valid = 1; op = LW; addr = 32'h10; rt_data = 32'h1;
    mem_waitrequest = 0; mem_readdata = 32'hDEAD_BEEF; mem_readdatavalid = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_error, mem_read, mem_write} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {req_ready, resp_valid, resp_error, mem_read, mem_write});
    end
    checks++;
    if ({resp_data, mem_address, mem_byteenable, mem_writedata} !== '0) begin
      errors++;
      $display("FAIL reset_data: got data %h addr %h be %b wd %h want all zero",
               resp_data, mem_address, mem_byteenable, mem_writedata);
    end
    reset = 0; req_valid = 0; mem_readdatavalid = 0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset: got %b want 1", req_ready);
    end
  endtask

  task automatic test_directed();
    obs_t ob;
    do_access(LB, 32'h1003, $urandom, 32'h80FF_1234, 0, 0, ob);
    checks++;
    if ({ob.data, ob.be, ob.err} !== {32'hFFFF_FF80, 4'b1000, 1'b0} || ob.lat != 3) begin
      errors++;
      $display("FAIL lb_sign: got data %h be %b err %b lat %0d want ffffff80 1000 0 3",
               ob.data, ob.be, ob.err, ob.lat);
    end
    do_access(LWR, 32'h2002, 32'hAABB_CCDD, 32'h1122_3344, 0, 0, ob);
    checks++;
    if ({ob.data, ob.be, ob.err} !== {32'hAABB_1122, 4'b1100, 1'b0}) begin
      errors++;
      $display("FAIL lwr_merge: got data %h be %b err %b want aabb1122 1100 0",
               ob.data, ob.be, ob.err);
    end
    do_access(SH, 32'h3002, 32'h0000_BEEF, 32'h0, 4, 0, ob);
    checks++;
    if ({ob.wd, ob.be, ob.err, ob.stable, ob.wr_seen} !== {32'hBEEF_BEEF, 4'b1100, 3'b011} ||
        ob.cmd_cycles != 5 || ob.lat != 6) begin
      errors++;
      $display("FAIL sh_wait: got wd %h be %b err %b stable %b cmd %0d lat %0d want beefbeef 1100 0 1 5 6",
               ob.wd, ob.be, ob.err, ob.stable, ob.cmd_cycles, ob.lat);
    end
    do_access(LW, 32'h4001, $urandom, 32'h0, 0, 0, ob);
    checks++;
    if ({ob.err, ob.rd_seen, ob.wr_seen, ob.data} !== {3'b100, 32'h0} || ob.lat != 1 ||
        !ob.one_shot) begin
      errors++;
      $display("FAIL lw_misaligned: got err %b rd %b wr %b data %h lat %0d one %b want 1 0 0 0 1 1",
               ob.err, ob.rd_seen, ob.wr_seen, ob.data, ob.lat, ob.one_shot);
    end
  endtask

  task automatic test_timeout();
    obs_t ob;
    logic quiet;
    do_access(LW, 32'h5000, $urandom, 32'h1234_5678, 0, -1, ob);
    checks++;
    if ({ob.err, ob.data, ob.strobe_at_resp} !== {1'b1, 32'h0, 1'b0} || ob.lat != TMO + 1) begin
      errors++;
      $display("FAIL rd_timeout: got err %b data %h strobe %b lat %0d want 1 0 0 %0d",
               ob.err, ob.data, ob.strobe_at_resp, ob.lat, TMO + 1);
    end
    quiet = 1;
    for (int i = 0; i < 3; i++) begin
      mem_readdatavalid = 1; mem_readdata = $urandom;
      @(negedge clk);
      if (resp_valid) quiet = 0;
    end
    mem_readdatavalid = 0;
    checks++;
    if (!quiet) begin errors++; $display("FAIL late_rdv: got resp_valid 1 want 0"); end
    do_access(LH, 32'h5002, $urandom, 32'h0, 20, 0, ob);
    checks++;
    if ({ob.err, ob.strobe_at_resp, ob.rd_seen} !== 3'b101 || ob.cmd_cycles != TMO ||
        ob.lat != TMO + 1) begin
      errors++;
      $display("FAIL cmd_timeout: got err %b strobe %b cmd %0d lat %0d want 1 0 %0d %0d",
               ob.err, ob.strobe_at_resp, ob.cmd_cycles, ob.lat, TMO, TMO + 1);
    end
    do_access(SW, 32'h5004, 32'h0BAD_F00D, 32'h0, TMO - 1, 0, ob);
    checks++;
    if (ob.err !== 1'b0 || ob.lat != TMO + 1) begin
      errors++;
      $display("FAIL wr_edge_release: got err %b lat %0d want 0 %0d", ob.err, ob.lat, TMO + 1);
    end
    do_access(SW, 32'h5008, 32'h0BAD_F00D, 32'h0, TMO, 0, ob);
    checks++;
    if (ob.err !== 1'b1 || ob.lat != TMO + 1) begin
      errors++;
      $display("FAIL wr_timeout: got err %b lat %0d want 1 %0d", ob.err, ob.lat, TMO + 1);
    end
    do_access(LW, 32'h500C, $urandom, 32'hCAFE_0001, 0, TMO - 2, ob);
    checks++;
    if ({ob.err, ob.data} !== {1'b0, 32'hCAFE_0001} || ob.lat != TMO + 1) begin
      errors++;
      $display("FAIL rdv_edge: got err %b data %h lat %0d want 0 cafe0001 %0d",
               ob.err, ob.data, ob.lat, TMO + 1);
    end
  endtask

  task automatic test_reset_mid();
    obs_t ob;
    logic quiet;
    // Reset while the read command is still being held off.
    @(negedge clk);
    req_valid = 1; op = LW; addr = 32'h6000; mem_waitrequest = 1;
    @(negedge clk);
    req_valid = 0;
    checks++;
    if (mem_read !== 1'b1) begin errors++; $display("FAIL rdcmd_strobe: got %b want 1", mem_read); end
    reset = 1;
    @(negedge clk);
    reset = 0; mem_waitrequest = 0;
    checks++;
    if ({mem_read, mem_write, resp_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_rdcmd: got %b want 000", {mem_read, mem_write, resp_valid});
    end
    // Reset in RD_WAIT, then late read data must be discarded.
    @(negedge clk);
    req_valid = 1; op = LW; addr = 32'h6004;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    checks++;
    if ({mem_read, mem_write, resp_valid, req_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_rdwait: got %b want 0000", {mem_read, mem_write, resp_valid, req_ready});
    end
    reset = 0;
    quiet = 1;
    for (int i = 0; i < 3; i++) begin
      mem_readdatavalid = 1; mem_readdata = $urandom;
      @(negedge clk);
      if (resp_valid) quiet = 0;
    end
    mem_readdatavalid = 0;
    checks++;
    if (!quiet) begin errors++; $display("FAIL reset_discard: got resp_valid 1 want 0"); end
    do_access(LBU, 32'h1001, $urandom, 32'h0000_9A00, 0, 0, ob);
    checks++;
    if ({ob.data, ob.err} !== {32'h0000_009A, 1'b0} || ob.lat != 3) begin
      errors++;
      $display("FAIL lbu_after_reset: got data %h err %b lat %0d want 0000009a 0 3",
               ob.data, ob.err, ob.lat);
    end
  endtask

  task automatic test_random();
    obs_t ob;
    exp_t e;
    logic [5:0]  o;
    logic [31:0] ad, rt, mw;
    int wr, rd;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) o = 6'($urandom_range(0, 31));
      else o = ops[$urandom_range(0, 11)];
      ad = $urandom; rt = $urandom; mw = $urandom;
      wr = $urandom_range(0, 3); rd = $urandom_range(0, 3);
      e = model(o, ad, rt, mw, wr, rd);
      do_access(o, ad, rt, mw, wr, rd, ob);
      checks++;
      if (ob.lat != e.lat || ob.err !== e.err || ob.data !== e.res) begin
        errors++;
        $display("FAIL rnd_resp op %h addr %h: got lat %0d err %b data %h want %0d %b %h",
                 o, ad, ob.lat, ob.err, ob.data, e.lat, e.err, e.res);
      end
      checks++;
      if (ob.rd_seen !== (e.ld && !e.bad) || ob.wr_seen !== (e.st && !e.bad) ||
          !ob.one_shot || !ob.ready) begin
        errors++;
        $display("FAIL rnd_bus op %h addr %h: got rd %b wr %b one %b rdy %b want %b %b 1 1",
                 o, ad, ob.rd_seen, ob.wr_seen, ob.one_shot, ob.ready,
                 e.ld && !e.bad, e.st && !e.bad);
      end
      if (!e.bad) begin
        checks++;
        if (ob.addr !== {ad[31:2], 2'b00} || ob.be !== e.be || !ob.stable ||
            (e.st && ob.wd !== e.wd)) begin
          errors++;
          $display("FAIL rnd_lanes op %h addr %h: got a %h be %b wd %h st %b want %h %b %h 1",
                   o, ad, ob.addr, ob.be, ob.wd, ob.stable, {ad[31:2], 2'b00}, e.be, e.wd);
        end
      end
    end
  endtask

  initial begin
    reset = 1; req_valid = 0; op = 0; addr = 0; rt_data = 0;
    mem_waitrequest = 0; mem_readdata = 0; mem_readdatavalid = 0;
    test_reset();
    test_directed();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
